// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU operand/result stream pair among NUM_REQ requesters.
// Optional per-requester issue counters are compiled in when ALU_ARB_STATS_EN is defined.
module alu_share_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int LVAL_SIZE   = 16,
  parameter int RVAL_SIZE   = 16,
  parameter int RESULT_SIZE = 32,
  parameter int TAG_DEPTH   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ*LVAL_SIZE-1:0]   s_req_lval_tdata,
  input  logic [NUM_REQ*RVAL_SIZE-1:0]   s_req_rval_tdata,
  input  logic [NUM_REQ-1:0]             s_req_tvalid,
  output logic [NUM_REQ-1:0]             s_req_tready,
  output logic [LVAL_SIZE-1:0]           m_lval_tdata,
  output logic                           m_lval_tvalid,
  input  logic                           m_lval_tready,
  output logic [RVAL_SIZE-1:0]           m_rval_tdata,
  output logic                           m_rval_tvalid,
  input  logic                           m_rval_tready,
  input  logic [RESULT_SIZE-1:0]         s_res_tdata,
  input  logic                           s_res_tvalid,
  output logic                           s_res_tready,
  output logic [NUM_REQ*RESULT_SIZE-1:0] m_res_tdata,
  output logic [NUM_REQ-1:0]             m_res_tvalid,
  input  logic [NUM_REQ-1:0]             m_res_tready,
`ifdef ALU_ARB_STATS_EN
  output logic [NUM_REQ*32-1:0]          stat_grant_cnt,
`endif
  output logic                           err_orphan
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {ARB, ISSUE} state_t;

  state_t              state_reg;
  logic [GW-1:0]       grant_reg;
  logic [GW-1:0]       last_reg;
  logic [CW-1:0]       count_reg;
  logic [PW-1:0]       wr_ptr_reg;
  logic [PW-1:0]       rd_ptr_reg;
  logic [GW-1:0]       tag_mem [TAG_DEPTH];
  logic                err_orphan_reg;

  logic [LVAL_SIZE-1:0] lval_slice [NUM_REQ];
  logic [RVAL_SIZE-1:0] rval_slice [NUM_REQ];

  logic                arb_found;
  logic [GW-1:0]       arb_pick;
  logic [GW-1:0]       scan_idx;
  logic                issue_valid;
  logic                issue_fire;
  logic                fifo_empty;
  logic [GW-1:0]       owner;
  logic                owner_valid;
  logic                res_fire;
  logic                bypass;
  logic                push;
  logic                pop;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign lval_slice[gi] = s_req_lval_tdata[gi*LVAL_SIZE +: LVAL_SIZE];
      assign rval_slice[gi] = s_req_rval_tdata[gi*RVAL_SIZE +: RVAL_SIZE];
      assign m_res_tdata[gi*RESULT_SIZE +: RESULT_SIZE] = s_res_tdata;
      assign m_res_tvalid[gi] = s_res_tvalid && owner_valid && (owner == GW'(gi));
      assign s_req_tready[gi] = issue_fire && (grant_reg == GW'(gi));
    end
  endgenerate

  // Scan starts one past the last served requester and wraps.
  always_comb begin
    arb_found = 1'b0;
    arb_pick  = last_reg;
    scan_idx  = last_reg;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = (scan_idx == GW'(NUM_REQ - 1)) ? '0 : scan_idx + GW'(1);
      if (!arb_found && s_req_tvalid[scan_idx]) begin
        arb_found = 1'b1;
        arb_pick  = scan_idx;
      end
    end
  end

  assign issue_valid   = (state_reg == ISSUE) && s_req_tvalid[grant_reg];
  assign m_lval_tvalid = issue_valid;
  assign m_rval_tvalid = issue_valid;
  assign m_lval_tdata  = lval_slice[grant_reg];
  assign m_rval_tdata  = rval_slice[grant_reg];
  assign issue_fire    = issue_valid && m_lval_tready && m_rval_tready;

  // With no tags outstanding, the op in ISSUE owns the result so a
  // combinational ALU can complete in the same cycle it is issued.
  assign fifo_empty   = (count_reg == '0);
  assign owner        = fifo_empty ? grant_reg : tag_mem[rd_ptr_reg];
  assign owner_valid  = !fifo_empty || (state_reg == ISSUE);
  assign s_res_tready = owner_valid && m_res_tready[owner];
  assign res_fire     = s_res_tvalid && s_res_tready;
  assign bypass       = fifo_empty && issue_fire && res_fire;
  assign push         = issue_fire && !bypass;
  assign pop          = res_fire && !fifo_empty;
  assign err_orphan   = err_orphan_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ARB;
      grant_reg <= '0;
      last_reg  <= GW'(NUM_REQ - 1);
    end else begin
      case (state_reg)
        ARB: begin
          if (arb_found && (count_reg < CW'(TAG_DEPTH))) begin
            grant_reg <= arb_pick;
            state_reg <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue_fire) begin
            last_reg  <= grant_reg;
            state_reg <= ARB;
          end
        end
        default: state_reg <= ARB;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr_reg] <= grant_reg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_orphan_reg <= 1'b0;
    end else if (s_res_tvalid && !owner_valid) begin
      err_orphan_reg <= 1'b1;
    end
  end

`ifdef ALU_ARB_STATS_EN
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_stat
      logic [31:0] cnt_reg;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_reg <= '0;
        end else if (s_req_tready[gi] && (cnt_reg != 32'hFFFF_FFFF)) begin
          cnt_reg <= cnt_reg + 32'd1;
        end
      end
      assign stat_grant_cnt[gi*32 +: 32] = cnt_reg;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed + randomized bench for alu_share_arbiter with a queue-based round-robin reference model.
module tb_alu_share_arbiter;
  localparam int N   = 4;
  localparam int LW  = 16;
  localparam int RW  = 16;
  localparam int RS  = 32;
  localparam int TD  = 4;
  localparam int LAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b0;
  logic [N*LW-1:0]   s_req_lval_tdata = '0;
  logic [N*RW-1:0]   s_req_rval_tdata = '0;
  logic [N-1:0]      s_req_tvalid = '0;
  logic [N-1:0]      s_req_tready;
  logic [LW-1:0]     m_lval_tdata;
  logic              m_lval_tvalid;
  logic              m_lval_tready;
  logic [RW-1:0]     m_rval_tdata;
  logic              m_rval_tvalid;
  logic              m_rval_tready;
  logic [RS-1:0]     s_res_tdata;
  logic              s_res_tvalid;
  logic              s_res_tready;
  logic [N*RS-1:0]   m_res_tdata;
  logic [N-1:0]      m_res_tvalid;
  logic [N-1:0]      m_res_tready = '0;
  logic              err_orphan;
`ifdef ALU_ARB_STATS_EN
  logic [N*32-1:0]   stat_grant_cnt;
`endif

  alu_share_arbiter #(
    .NUM_REQ(N), .LVAL_SIZE(LW), .RVAL_SIZE(RW), .RESULT_SIZE(RS), .TAG_DEPTH(TD)
  ) dut (
    .clk(clk), .rst(rst),
    .s_req_lval_tdata(s_req_lval_tdata), .s_req_rval_tdata(s_req_rval_tdata),
    .s_req_tvalid(s_req_tvalid), .s_req_tready(s_req_tready),
    .m_lval_tdata(m_lval_tdata), .m_lval_tvalid(m_lval_tvalid), .m_lval_tready(m_lval_tready),
    .m_rval_tdata(m_rval_tdata), .m_rval_tvalid(m_rval_tvalid), .m_rval_tready(m_rval_tready),
    .s_res_tdata(s_res_tdata), .s_res_tvalid(s_res_tvalid), .s_res_tready(s_res_tready),
    .m_res_tdata(m_res_tdata), .m_res_tvalid(m_res_tvalid), .m_res_tready(m_res_tready),
`ifdef ALU_ARB_STATS_EN
    .stat_grant_cnt(stat_grant_cnt),
`endif
    .err_orphan(err_orphan)
  );

  // ALU model: mode 0 combinational adder, mode 1 pipelined adder, mode 2 injected result
  int            alu_mode   = 0;
  logic          alu_lrdy   = 1'b1;
  logic          inj_valid  = 1'b0;
  logic          pipe_flush = 1'b0;
  logic [RS-1:0] alu_sum;
  logic [RS-1:0] pipe_d [16];
  int            pipe_t [16];
  int            ph = 0, pt = 0, cyc = 0;
  logic          pipe_has;

  assign alu_sum  = RS'(m_lval_tdata) + RS'(m_rval_tdata);
  assign pipe_has = (ph != pt) && (pipe_t[ph % 16] <= cyc);
  assign s_res_tvalid  = (alu_mode == 0) ? (m_lval_tvalid && m_rval_tvalid) :
                         (alu_mode == 1) ? pipe_has : inj_valid;
  assign s_res_tdata   = (alu_mode == 0) ? alu_sum :
                         (alu_mode == 1) ? pipe_d[ph % 16] : 32'hDEAD_BEEF;
  assign m_lval_tready = (alu_mode == 0) ? s_res_tready : ((alu_mode == 1) && alu_lrdy);
  assign m_rval_tready = (alu_mode == 0) ? s_res_tready : (alu_mode == 1);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pipe_flush) ph <= pt;
    else if (alu_mode == 1 && s_res_tvalid && s_res_tready) ph <= ph + 1;
    if (alu_mode == 1 && m_lval_tvalid && m_rval_tvalid && m_lval_tready && m_rval_tready) begin
      pipe_d[pt % 16] <= alu_sum;
      pipe_t[pt % 16] <= cyc + LAT;
      pt <= pt + 1;
    end
  end

  // Requester operand queues, observations and the reference model
  logic [LW-1:0] op_l [N][64];
  logic [RW-1:0] op_r [N][64];
  int            op_hd [N];
  int            op_tl [N];
  int            obs_iss[$];
  int            obs_rreq[$];
  logic [RS-1:0] obs_rdat[$];
  int            exp_req[$];
  logic [RS-1:0] exp_data[$];
  int            m_last = N - 1;
  int            n_checks = 0;
  int            n_fail = 0;
  int            onehot_bad = 0;
  bit            rdy_rand = 0;
  bit            lrdy_rand = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      s_req_tvalid[i] = (op_hd[i] != op_tl[i]);
      s_req_lval_tdata[i*LW +: LW] = op_l[i][op_hd[i] % 64];
      s_req_rval_tdata[i*RW +: RW] = op_r[i][op_hd[i] % 64];
    end
  endtask

  task automatic load(input int i, input logic [LW-1:0] l, input logic [RW-1:0] r);
    op_l[i][op_tl[i] % 64] = l;
    op_r[i][op_tl[i] % 64] = r;
    op_tl[i]++;
  endtask

  // Round-robin rule applied to the set of requesters with pending operands.
  task automatic predict();
    int pend [N];
    int idx [N];
    int any;
    for (int i = 0; i < N; i++) begin pend[i] = op_tl[i] - op_hd[i]; idx[i] = op_hd[i]; end
    do begin
      any = 0;
      for (int k = 1; k <= N && any == 0; k++) begin
        int j;
        j = (m_last + k) % N;
        if (pend[j] > 0) begin
          exp_req.push_back(j);
          exp_data.push_back(RS'(op_l[j][idx[j] % 64]) + RS'(op_r[j][idx[j] % 64]));
          pend[j]--; idx[j]++; m_last = j; any = 1;
        end
      end
    end while (any != 0);
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (op_hd[i] != op_tl[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic tick();
    bit acc [N];
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      acc[i] = s_req_tvalid[i] && s_req_tready[i];
      if (acc[i]) begin
        obs_iss.push_back(i);
        $display("%0t issue req%0d lval=%0h rval=%0h", $time, i, m_lval_tdata, m_rval_tdata);
      end
      if (m_res_tvalid[i] && m_res_tready[i]) begin
        obs_rreq.push_back(i);
        obs_rdat.push_back(m_res_tdata[i*RS +: RS]);
        $display("%0t result req%0d data=%0h", $time, i, m_res_tdata[i*RS +: RS]);
      end
    end
    if (!$onehot0(m_res_tvalid) || !$onehot0(s_req_tready)) onehot_bad++;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) if (acc[i]) op_hd[i]++;
    if (rdy_rand) m_res_tready = N'($urandom);
    if (lrdy_rand) alu_lrdy = 1'($urandom);
    drive();
    #1;
  endtask

  task automatic clear_obs();
    obs_iss.delete(); obs_rreq.delete(); obs_rdat.delete();
    exp_req.delete(); exp_data.delete();
  endtask

  task automatic run_and_compare(input string tag, input int budget);
    int n;
    bit done;
    n = 0;
    done = all_empty() && (obs_rreq.size() >= exp_req.size());
    while (!done && n < budget) begin
      tick();
      n++;
      done = all_empty() && (obs_rreq.size() >= exp_req.size());
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_n_iss"}, obs_iss.size(), exp_req.size());
    check({tag, "_n_res"}, obs_rreq.size(), exp_req.size());
    for (int k = 0; k < exp_req.size(); k++) begin
      if (k < obs_iss.size())  check($sformatf("%s_iss%0d", tag, k), obs_iss[k], exp_req[k]);
      if (k < obs_rreq.size()) begin
        check($sformatf("%s_rreq%0d", tag, k), obs_rreq[k], exp_req[k]);
        check($sformatf("%s_rdat%0d", tag, k), obs_rdat[k], exp_data[k]);
      end
    end
    clear_obs();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < N; i++) op_hd[i] = op_tl[i];
    drive();
    m_last = N - 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    clear_obs();
  endtask

  initial begin
    int first_req;
    logic [LW-1:0] first_l;
    logic [RW-1:0] first_r;
    int guard;
    for (int i = 0; i < N; i++) begin op_hd[i] = 0; op_tl[i] = 0; end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_req_tready", s_req_tready, 0);
    check("rst_m_lval_tvalid", m_lval_tvalid, 0);
    check("rst_m_rval_tvalid", m_rval_tvalid, 0);
    check("rst_s_res_tready", s_res_tready, 0);
    check("rst_m_res_tvalid", m_res_tvalid, 0);
    check("rst_err_orphan", err_orphan, 0);
    do_reset();

    // T1: single op through a combinational adder
    alu_mode = 0; m_res_tready = '1;
    load(1, 16'd3, 16'd4); predict(); drive();
    tick();
    check("t1_s_req_tready", s_req_tready, 4'b0010);
    check("t1_m_res_tvalid", m_res_tvalid, 4'b0010);
    check("t1_res_data", m_res_tdata[63:32], 32'd7);
    check("t1_lval", m_lval_tdata, 16'd3);
    tick();
    check("t1_tready_pulse", s_req_tready, 0);
    check("t1_res_gone", m_res_tvalid, 0);
    run_and_compare("t1", 10);

    // T2: fairness with all four requesters loaded from reset
    do_reset();
    for (int i = 0; i < N; i++) for (int k = 0; k < 2; k++) load(i, LW'($urandom), RW'($urandom));
    predict(); drive();
    run_and_compare("t2", 100);

    // T3: pipelined ALU, results blocked -> tag FIFO fills
    do_reset();
    alu_mode = 1; alu_lrdy = 1'b1; m_res_tready = '0;
    for (int i = 0; i < N; i++) for (int k = 0; k < 2; k++) load(i, LW'($urandom), RW'($urandom));
    predict(); drive();
    repeat (20) tick();
    check("t3_issues_at_full", obs_iss.size(), TD);
    check("t3_no_tready", s_req_tready, 0);
    check("t3_head_owner", m_res_tvalid, 4'(1 << exp_req[0]));
    m_res_tready = '1;
    run_and_compare("t3", 200);

    // T4: operand backpressure keeps the grant and data locked
    alu_mode = 1; alu_lrdy = 1'b0; m_res_tready = '1;
    load(2, LW'($urandom), RW'($urandom));
    load(3, LW'($urandom), RW'($urandom));
    predict(); drive();
    first_req = exp_req[0];
    first_l = op_l[first_req][op_hd[first_req] % 64];
    first_r = op_r[first_req][op_hd[first_req] % 64];
    tick();
    for (int c = 0; c < 5; c++) begin
      check($sformatf("t4_tready_c%0d", c), s_req_tready, 0);
      check($sformatf("t4_lvalid_c%0d", c), m_lval_tvalid, 1);
      check($sformatf("t4_lval_c%0d", c), m_lval_tdata, first_l);
      check($sformatf("t4_rval_c%0d", c), m_rval_tdata, first_r);
      check($sformatf("t4_nores_c%0d", c), s_res_tvalid, 0);
      tick();
    end
    alu_lrdy = 1'b1;
    run_and_compare("t4", 100);

    // Randomized traffic in both ALU modes with random ready patterns
    for (int it = 0; it < 4; it++) begin
      alu_mode = it % 2;
      rdy_rand = 1; lrdy_rand = (alu_mode == 1);
      for (int i = 0; i < N; i++) begin
        int cnt;
        cnt = int'($urandom_range(0, 5));
        for (int k = 0; k < cnt; k++) load(i, LW'($urandom), RW'($urandom));
      end
      predict(); drive();
      run_and_compare($sformatf("rnd%0d", it), 2000);
    end
    rdy_rand = 0; lrdy_rand = 0; alu_lrdy = 1'b1; m_res_tready = '1;

    // T5: orphan result in ARB with no outstanding tags
    do_reset();
    alu_mode = 2; inj_valid = 1'b1;
    #1;
    check("t5_s_res_tready", s_res_tready, 0);
    check("t5_m_res_tvalid", m_res_tvalid, 0);
    check("t5_err_before", err_orphan, 0);
    tick();
    check("t5_err_set", err_orphan, 1);
    inj_valid = 1'b0;
    repeat (3) tick();
    check("t5_err_sticky", err_orphan, 1);

    // T6: reset with two ops outstanding in a pipelined ALU
    alu_mode = 1; alu_lrdy = 1'b1; m_res_tready = '0;
    load(0, LW'($urandom), RW'($urandom));
    load(1, LW'($urandom), RW'($urandom));
    drive();
    guard = 0;
    while (obs_iss.size() < 2 && guard < 30) begin tick(); guard++; end
    check("t6_two_issued", obs_iss.size(), 2);
    rst = 1'b0;
    #1;
    check("t6_rst_outputs", {s_req_tready, m_lval_tvalid, m_rval_tvalid, s_res_tready, m_res_tvalid}, 0);
    check("t6_rst_err", err_orphan, 0);
`ifdef ALU_ARB_STATS_EN
    check("t6_stats_zero", stat_grant_cnt, 0);
`endif
    for (int i = 0; i < N; i++) op_hd[i] = op_tl[i];
    drive();
    m_last = N - 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    clear_obs();
    repeat (5) tick();
    check("t6_late_orphan", err_orphan, 1);
    check("t6_late_tready", s_res_tready, 0);
    pipe_flush = 1'b1; tick(); pipe_flush = 1'b0;
    alu_mode = 0; m_res_tready = '1;
    for (int k = 0; k < 3; k++) load(0, LW'($urandom), RW'($urandom));
    predict(); drive();
    run_and_compare("t6", 50);
    check("t6_err_still", err_orphan, 1);
`ifdef ALU_ARB_STATS_EN
    check("t6_stats_req0", stat_grant_cnt[31:0], 3);
`endif

    check("onehot_outputs", onehot_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
